// File: rtl/shift_rotate_unit_if.sv
// shift_rotate_unit_if: request/result bus between the sequencer (master) and the shift/rotate unit (slave)
interface shift_rotate_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic [2:0]       mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic             busy;
  logic             done;
  modport master(output start, mode, a, b, input result, busy, done);
  modport slave(input start, mode, a, b, output result, busy, done);
endinterface

// File: rtl/shift_rotate_unit.sv
// shift_rotate_unit: multi-cycle shr/shra/shl/ror/rol, up to STEP bits per cycle
// Ports: clk, reset (sync, active-high), bus (slave): start/mode/a/b in, result/busy/done out.
// Build option SHIFT_ROTATE_UNIT_EARLY_EXIT_EN: finish after ceil(amount/STEP) cycles instead of WIDTH/STEP.
module shift_rotate_unit #(
  parameter int WIDTH = 32,
  parameter int STEP  = 4
) (
  input logic clk,
  input logic reset,
  shift_rotate_unit_if.slave bus
);
  localparam int AW = $clog2(WIDTH);
  localparam logic [AW:0] STEP_W = (AW+1)'(STEP);
  localparam logic [WIDTH-1:0] ONES = '1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t st, st_n;
  logic [WIDTH-1:0] w, w_n;
  logic [AW-1:0] rem;
  logic [AW:0] s;
  logic [2:0] md;
  logic sgn, last, zero_go;
  logic unused_b;
  assign unused_b = ^bus.b[WIDTH-1:AW];
`ifdef SHIFT_ROTATE_UNIT_EARLY_EXIT_EN
  assign last    = (rem - s[AW-1:0]) == '0;
  assign zero_go = bus.b[AW-1:0] == '0;
`else
  localparam int NRUN = WIDTH / STEP;
  localparam int CW = $clog2(NRUN + 1);
  logic [CW-1:0] cnt;
  assign last    = cnt == CW'(NRUN - 1);
  assign zero_go = 1'b0;
  always_ff @(posedge clk)
    if (reset || st != RUN) cnt <= '0;
    else cnt <= cnt + 1'b1;
`endif
  always_comb begin
    s = ({1'b0, rem} < STEP_W) ? {1'b0, rem} : STEP_W;
    w_n = md == 3'd0 ? w >> s :
          md == 3'd1 ? (w >> s) | (sgn ? ~(ONES >> s) : '0) :
          md == 3'd2 ? w << s :
          md == 3'd3 ? (w >> s) | (w << (WIDTH - s)) :
          md == 3'd4 ? (w << s) | (w >> (WIDTH - s)) : w;
    st_n = st;
    if (st == IDLE && bus.start) st_n = zero_go ? DONE : RUN;
    else if (st == RUN && last) st_n = DONE;
    else if (st == DONE) st_n = IDLE;
  end
  always_ff @(posedge clk)
    st <= reset ? IDLE : st_n;
  always_ff @(posedge clk)
    if (reset) begin
      w   <= '0;
      rem <= '0;
      md  <= '0;
      sgn <= 1'b0;
    end else if (st == IDLE && bus.start) begin
      w   <= bus.a;
      rem <= bus.b[AW-1:0];
      md  <= bus.mode;
      sgn <= bus.a[WIDTH-1];
    end else if (st == RUN) begin
      w   <= w_n;
      rem <= rem - s[AW-1:0];
    end
  assign bus.result = w;
  assign bus.busy   = st == RUN;
  assign bus.done   = st == DONE;
endmodule

// File: tb/tb_shift_rotate_unit.sv
// tb_shift_rotate_unit: directed self-checking bench for shift_rotate_unit (WIDTH=32, STEP=4)
module tb_shift_rotate_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  shift_rotate_unit_if #(.WIDTH(32)) bus();
  shift_rotate_unit #(.WIDTH(32), .STEP(4)) dut(.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  function automatic int lat(input int amt);
`ifdef SHIFT_ROTATE_UNIT_EARLY_EXIT_EN
    return (amt + 3) / 4;
`else
    return 8;
`endif
  endfunction

  // Issues one request and observes 20 cycles after the accept edge.
  task automatic do_op(input logic [2:0] m, input logic [31:0] av, input logic [31:0] bv,
                       input int inj, input logic [31:0] a2,
                       output int dcyc, output int bcnt, output int dcnt, output int ov,
                       output logic [31:0] res, output logic [31:0] res_end);
    dcyc = -1; bcnt = 0; dcnt = 0; ov = 0; res = 'x;
    bus.start = 1'b1; bus.mode = m; bus.a = av; bus.b = bv;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (bus.busy) bcnt++;
      if (bus.done) dcnt++;
      if (bus.busy && bus.done) ov++;
      if (bus.done && dcyc < 0) begin dcyc = c; res = bus.result; end
      bus.start = (c == inj);
      if (c == inj) bus.a = a2;
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    res_end = bus.result;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.start = 1'b0; bus.mode = 3'd0; bus.a = '0; bus.b = '0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.done); end
    total++; if (bus.result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h want=0", bus.result); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_rol20();
    int d, bc, dc, ov; logic [31:0] r, re;
    do_op(3'd4, 32'h00000012, 32'h00000014, -1, 0, d, bc, dc, ov, r, re);
    total++; if (r !== 32'h01200000) begin bad++; $display("FAIL rol20_result got=%h want=01200000", r); end
    total++; if (d !== lat(20) + 1) begin bad++; $display("FAIL rol20_done_cycle got=%0d want=%0d", d, lat(20) + 1); end
    total++; if (bc !== lat(20)) begin bad++; $display("FAIL rol20_busy_cycles got=%0d want=%0d", bc, lat(20)); end
    total++; if (dc !== 1) begin bad++; $display("FAIL rol20_done_pulses got=%0d want=1", dc); end
    total++; if (ov !== 0) begin bad++; $display("FAIL rol20_busy_done_overlap got=%0d want=0", ov); end
  endtask

  task automatic test_rotate_one();
    int d, bc, dc, ov; logic [31:0] r, re;
    do_op(3'd3, 32'h00000001, 32'h1, -1, 0, d, bc, dc, ov, r, re);
    total++; if (r !== 32'h80000000) begin bad++; $display("FAIL ror1_result got=%h want=80000000", r); end
    total++; if (d !== lat(1) + 1) begin bad++; $display("FAIL ror1_done_cycle got=%0d want=%0d", d, lat(1) + 1); end
    do_op(3'd4, 32'h80000000, 32'h1, -1, 0, d, bc, dc, ov, r, re);
    total++; if (r !== 32'h00000001) begin bad++; $display("FAIL rol1_result got=%h want=00000001", r); end
    total++; if (d !== lat(1) + 1) begin bad++; $display("FAIL rol1_done_cycle got=%0d want=%0d", d, lat(1) + 1); end
  endtask

  task automatic test_fill();
    int d, bc, dc, ov; logic [31:0] r, re;
    do_op(3'd1, 32'h80000000, 32'd31, -1, 0, d, bc, dc, ov, r, re);
    total++; if (r !== 32'hFFFFFFFF) begin bad++; $display("FAIL shra31_result got=%h want=ffffffff", r); end
    total++; if (d !== lat(31) + 1) begin bad++; $display("FAIL shra31_done_cycle got=%0d want=%0d", d, lat(31) + 1); end
    do_op(3'd0, 32'h80000000, 32'd31, -1, 0, d, bc, dc, ov, r, re);
    total++; if (r !== 32'h00000001) begin bad++; $display("FAIL shr31_result got=%h want=00000001", r); end
    do_op(3'd1, 32'h40000000, 32'd30, -1, 0, d, bc, dc, ov, r, re);
    total++; if (r !== 32'h00000001) begin bad++; $display("FAIL shra_pos_result got=%h want=00000001", r); end
    do_op(3'd2, 32'h0000FFFF, 32'd16, -1, 0, d, bc, dc, ov, r, re);
    total++; if (r !== 32'hFFFF0000) begin bad++; $display("FAIL shl16_result got=%h want=ffff0000", r); end
    do_op(3'd5, 32'hA5A5A5A5, 32'd7, -1, 0, d, bc, dc, ov, r, re);
    total++; if (r !== 32'hA5A5A5A5) begin bad++; $display("FAIL pass_result got=%h want=a5a5a5a5", r); end
    total++; if (d !== lat(7) + 1) begin bad++; $display("FAIL pass_done_cycle got=%0d want=%0d", d, lat(7) + 1); end
  endtask

  task automatic test_upper_bits_and_ignore();
    int d, bc, dc, ov; logic [31:0] r, re;
    do_op(3'd2, 32'h0000FFFF, 32'hFFFFFF10, 2, 32'h12345678, d, bc, dc, ov, r, re);
    total++; if (r !== 32'hFFFF0000) begin bad++; $display("FAIL upper_b_result got=%h want=ffff0000", r); end
    total++; if (d !== lat(16) + 1) begin bad++; $display("FAIL upper_b_done_cycle got=%0d want=%0d", d, lat(16) + 1); end
    total++; if (dc !== 1) begin bad++; $display("FAIL ignored_start_done_pulses got=%0d want=1", dc); end
    total++; if (re !== 32'hFFFF0000) begin bad++; $display("FAIL ignored_start_held got=%h want=ffff0000", re); end
  endtask

  task automatic test_zero_amount();
    int d, bc, dc, ov; logic [31:0] r, re;
    do_op(3'd4, 32'hDEADBEEF, 32'h0, -1, 0, d, bc, dc, ov, r, re);
    total++; if (r !== 32'hDEADBEEF) begin bad++; $display("FAIL zero_result got=%h want=deadbeef", r); end
    total++; if (d !== lat(0) + 1) begin bad++; $display("FAIL zero_done_cycle got=%0d want=%0d", d, lat(0) + 1); end
    total++; if (bc !== lat(0)) begin bad++; $display("FAIL zero_busy_cycles got=%0d want=%0d", bc, lat(0)); end
    total++; if (dc !== 1) begin bad++; $display("FAIL zero_done_pulses got=%0d want=1", dc); end
  endtask

  task automatic test_reset_in_run();
    int d, bc, dc, ov; logic [31:0] r, re;
    bus.start = 1'b1; bus.mode = 3'd2; bus.a = 32'h1; bus.b = 32'd28;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL pre_reset_busy got=%b want=1", bus.busy); end
    reset = 1'b1; bus.start = 1'b1; bus.mode = 3'd3; bus.a = 32'hF0000000; bus.b = 32'd4;
    @(posedge clk); #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL run_reset_busy got=%b want=0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL run_reset_done got=%b want=0", bus.done); end
    total++; if (bus.result !== 32'h0) begin bad++; $display("FAIL run_reset_result got=%h want=0", bus.result); end
    @(posedge clk); #1;
    total++; if (bus.busy !== 1'b0 || bus.result !== 32'h0) begin bad++; $display("FAIL start_during_reset busy=%b result=%h want busy=0 result=0", bus.busy, bus.result); end
    reset = 1'b0;
    do_op(3'd3, 32'hF0000000, 32'd4, -1, 0, d, bc, dc, ov, r, re);
    total++; if (r !== 32'h0F000000) begin bad++; $display("FAIL post_reset_ror_result got=%h want=0f000000", r); end
    total++; if (d !== lat(4) + 1) begin bad++; $display("FAIL post_reset_done_cycle got=%0d want=%0d", d, lat(4) + 1); end
  endtask

  initial begin
    test_reset();
    test_rol20();
    test_rotate_one();
    test_fill();
    test_upper_bits_and_ignore();
    test_zero_amount();
    test_reset_in_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/shift_rotate_unit.md
# shift_rotate_unit

Parametrised multi-cycle shift/rotate execution unit for the CPU datapath. It performs shr, shra, shl, ror and rol on a WIDTH-bit operand, shifting by up to STEP bit positions per clock instead of using a full-width barrel shifter. The control sequencer starts it with a one-cycle `start` pulse and waits for `done`. It then moves `result` onto the bus through the Z path.

## Interface
- `WIDTH`, 32: operand/result width; power of two, ≥ 8. Local `AW = log2(WIDTH)`.
- `STEP`, 4: maximum shift distance per RUN cycle; power of two, 1..WIDTH.

- `clk`  in  1: single clock, all state updates on rising edge.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: request; accepted only in IDLE.
- `mode`  in  3: 000 shr, 001 shra, 010 shl, 011 ror, 100 rol, 101–111 pass-through.
- `a`  in  WIDTH: operand, sampled at accept.
- `b`  in  WIDTH: shift amount source; only `b[AW-1:0]` used, upper bits ignored; sampled at accept.
- `result`  out  WIDTH: shifted value; valid in DONE, held until next accept or reset.
- `busy`  out  1: high in RUN.
- `done`  out  1: one-cycle pulse in DONE.

## Operation
- States: IDLE, RUN, DONE. Reset (any state) → IDLE on the next edge. After reset: `result` = 0, `busy` = 0, `done` = 0.
- Accept: IDLE and `start` = 1 at an edge. Latch `a` into the working register, `b[AW-1:0]` into `remaining`, and `mode`. Go to RUN, or go straight to DONE if N = 0.
- RUN, each cycle: shift the working register by `s = min(STEP, remaining)` and set `remaining -= s`. When `s` = 0, the register holds its value.
- N = number of RUN cycles (see Configuration). After the N-th RUN edge → DONE. DONE → IDLE after one cycle.
- Fill rules:
  - shr/shl fill with zeros.
  - shra replicates the bit at position WIDTH-1, captured at accept.
  - ror/rol are modulo WIDTH; no bits are lost.
- Amount range is 0..WIDTH-1. An amount ≥ WIDTH cannot occur because the upper bits of `b` are ignored.
- Pass-through modes: working register unchanged; same N as a valid mode.
- `start` while in RUN or DONE is ignored; it is not queued. A new request must be presented in IDLE.
- `result` equals the working register. It is overwritten at the next accept.

## Timing
- Accept at edge k → `busy` = 1 for cycles k+1..k+N → `done` = 1 in cycle k+N+1 → IDLE in cycle k+N+2. Earliest next accept is at edge k+N+2.
- `busy` and `done` are never high together.
- If N = 0: `done` in cycle k+1; `busy` never rises.
- Reset asserted in RUN or DONE: at the next edge `busy`, `done` and `result` are all 0 and the state is IDLE. A `start` held during reset is ignored; it is accepted at the first edge with reset low.

## Configuration
- `SHIFT_ROTATE_UNIT_EARLY_EXIT_EN`:
  - Defined: N = ceil(amount / STEP), so N = 0 for amount 0. Latency depends on data.
  - Undefined (default): N = WIDTH/STEP for every request, including amount 0. Cycles after `remaining` reaches 0 hold the value. This gives constant-time latency, so the sequencer uses a fixed T-step count.
- Result values are identical in both builds; only `busy`/`done` timing differs.

## Test plan
All scenarios use WIDTH=32, STEP=4, and both macro settings unless noted.
- rol: a=0x00000012, b=0x00000014 (20) → result 0x01200000. `done` at k+9 with macro undefined; at k+6 with macro defined.
- ror: a=0x00000001, b=1 → 0x80000000. rol: a=0x80000000, b=1 → 0x00000001. Early-exit `done` at k+2.
- Sign and zero fill with a=0x80000000, b=31: shra → 0xFFFFFFFF, shr → 0x00000001, shl with a=0x0000FFFF, b=16 → 0xFFFF0000.
- Upper bits of `b`: a=0x0000FFFF, b=0xFFFFFF10 → amount 16, shl result 0xFFFF0000. Second `start` pulsed mid-RUN with a=0x12345678 → ignored; `result` stays 0xFFFF0000 and exactly one `done` pulse occurs.
- Zero amount: rol, a=0xDEADBEEF, b=0 → 0xDEADBEEF. Early exit: `done` at k+1 and `busy` never high. Fixed: `done` at k+9.
- Reset during RUN of shl 0x1 by 28: next edge → `busy`=0, `done`=0, `result`=0. A new accept of ror 0xF0000000 by 4 → 0x0F000000 with normal latency.
